// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller states for the parametrised LCD image controller.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_ROTL  = 4'd8;
  localparam logic [3:0] CMD_ROTR  = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    IDLE  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator; rotate/mirror exist only with LCD_CTRL_ROT_EN.
// Window layout is [a b; c d]; unhandled codes pass the window through unchanged.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] oa,
  output logic [DW-1:0] ob,
  output logic [DW-1:0] oc,
  output logic [DW-1:0] od
);

  logic [DW-1:0] mx_ab, mx_cd, mx;
  logic [DW-1:0] mn_ab, mn_cd, mn;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;

  assign mx_ab = (a > b) ? a : b;
  assign mx_cd = (c > d) ? c : d;
  assign mx    = (mx_ab > mx_cd) ? mx_ab : mx_cd;
  assign mn_ab = (a < b) ? a : b;
  assign mn_cd = (c < d) ? c : d;
  assign mn    = (mn_ab < mn_cd) ? mn_ab : mn_cd;
  assign sum   = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  assign avg   = DW'(sum >> 2);

  always_comb begin
    oa = a;
    ob = b;
    oc = c;
    od = d;
    case (op)
      CMD_MAX: begin oa = mx;  ob = mx;  oc = mx;  od = mx;  end
      CMD_MIN: begin oa = mn;  ob = mn;  oc = mn;  od = mn;  end
      CMD_AVG: begin oa = avg; ob = avg; oc = avg; od = avg; end
`ifdef LCD_CTRL_ROT_EN
      CMD_ROTL: begin oa = b; ob = d; oc = a; od = c; end
      CMD_ROTR: begin oa = c; ob = a; oc = d; od = b; end
      CMD_MIRX: begin oa = c; ob = d; oc = a; od = b; end
      CMD_MIRY: begin oa = b; ob = a; oc = d; od = c; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: IROM burst load, 2x2 window commands, IRB write-out.
// Optional macro LCD_CTRL_ROT_EN enables rotate/mirror commands 8-11.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [AW-1:0] IRB_A,
  output logic [DW-1:0] IRB_D,
  output logic          busy,
  output logic          done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int N  = IMG_W * IMG_H;

  state_t        state;
  logic [XW-1:0] px, px_m;
  logic [YW-1:0] py, py_m;
  logic [3:0]    cmd_r;
  logic          load_go;
  logic          cap_v;
  logic [AW-1:0] cap_a;
  logic [DW-1:0] pix [N];
  logic [AW-1:0] addr_a, addr_b, addr_c, addr_d;
  logic [DW-1:0] oa, ob, oc, od;

  assign px_m   = px - XW'(1);
  assign py_m   = py - YW'(1);
  assign addr_a = {py_m, px_m};
  assign addr_b = {py_m, px};
  assign addr_c = {py,   px_m};
  assign addr_d = {py,   px};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  lcd_win_alu #(.DW(DW)) u_alu (
    .op (cmd_r),
    .a  (pix[addr_a]),
    .b  (pix[addr_b]),
    .c  (pix[addr_c]),
    .d  (pix[addr_d]),
    .oa (oa),
    .ob (ob),
    .oc (oc),
    .od (od)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      px      <= XW'(IMG_W/2);
      py      <= YW'(IMG_H/2);
      cmd_r   <= '0;
      load_go <= 1'b0;
      cap_v   <= 1'b0;
      cap_a   <= '0;
      IROM_EN <= 1'b1;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_A   <= '0;
      IRB_D   <= '0;
    end else begin
      cap_v <= 1'b0;
      case (state)
        LOAD: begin
          // ROM data lags the address by one cycle, so capture tracks a delayed copy.
          cap_v <= ~IROM_EN;
          cap_a <= IROM_A;
          if (!load_go) begin
            load_go <= 1'b1;
            IROM_EN <= 1'b0;
            IROM_A  <= '0;
          end else if (!IROM_EN) begin
            if (IROM_A == AW'(N-1)) IROM_EN <= 1'b1;
            else                    IROM_A  <= IROM_A + 1'b1;
          end
          if (cap_v && cap_a == AW'(N-1)) state <= IDLE;
        end
        IDLE: begin
          if (cmd_valid) begin
            cmd_r <= cmd;
            if (cmd == CMD_WRITE) begin
              state  <= WRITE;
              IRB_RW <= 1'b0;
              IRB_A  <= '0;
              IRB_D  <= pix[0];
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          case (cmd_r)
            CMD_UP:    if (py != YW'(1))       py <= py - YW'(1);
            CMD_DOWN:  if (py != YW'(IMG_H-1)) py <= py + YW'(1);
            CMD_LEFT:  if (px != XW'(1))       px <= px - XW'(1);
            CMD_RIGHT: if (px != XW'(IMG_W-1)) px <= px + XW'(1);
            default: ;
          endcase
          state <= IDLE;
        end
        WRITE: begin
          if (IRB_A == AW'(N-1)) begin
            IRB_RW <= 1'b1;
            state  <= DONE;
          end else begin
            IRB_A <= IRB_A + 1'b1;
            IRB_D <= pix[IRB_A + 1'b1];
          end
        end
        DONE:    state <= IDLE;
        default: state <= LOAD;
      endcase
    end
  end

  // Window write-back is unconditional in EXEC; non-ALU codes return the window unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD && cap_v) pix[cap_a] <= IROM_Q;
      if (state == EXEC) begin
        pix[addr_a] <= oa;
        pix[addr_b] <= ob;
        pix[addr_c] <= oc;
        pix[addr_d] <= od;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench for lcd_ctrl_param (8x8, DW=8, IROM[k]=k); honours LCD_CTRL_ROT_EN.
module tb_lcd_ctrl_param;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic [7:0] IROM_Q = 8'd0;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [5:0] IRB_A;
  logic [7:0] IRB_D;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int exp_done = 0;
  int model [N];

  typedef struct {
    int a;
    int d;
  } exp_t;
  exp_t sb [$];

  lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_Q    (IROM_Q),
    .IROM_EN   (IROM_EN),
    .IROM_A    (IROM_A),
    .IRB_RW    (IRB_RW),
    .IRB_A     (IRB_A),
    .IRB_D     (IRB_D),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) IROM_Q <= 8'(IROM_A);

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every active IRB write cycle is matched against the next expected pixel.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) done_seen++;
    if (IRB_RW === 1'b0) begin
      if (sb.size() == 0) begin
        check("irb_unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("irb_addr", int'(IRB_A), e.a);
        check("irb_data", int'(IRB_D), e.d);
      end
    end
  end

  task automatic reset_load();
    int cyc;
    reset = 1'b1;
    @(negedge clk);
    check("rst_irom_en", IROM_EN, 1);
    check("rst_irom_a", IROM_A, 0);
    check("rst_irb_rw", IRB_RW, 1);
    check("rst_irb_a", IRB_A, 0);
    check("rst_irb_d", IRB_D, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    sb.delete();
    reset = 1'b0;
    for (int k = 0; k < N; k++) model[k] = k;
    @(negedge clk);
    check("t0_irom_en", IROM_EN, 0);
    check("t0_irom_a", IROM_A, 0);
    cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin cmd = 4'd3; cmd_valid = 1'b1; end
      if (cyc == 9) cmd_valid = 1'b0;
      if (cyc == 10) check("load_irom_a", IROM_A, 10);
      if (cyc == N) check("tN_irom_en", IROM_EN, 1);
    end
    cmd_valid = 1'b0;
    check("load_cycles", cyc, N + 1);
  endtask

  task automatic issue(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("exec_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask

  task automatic start_write();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.a = k;
      e.d = model[k];
      sb.push_back(e);
    end
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_out();
    int cyc;
    start_write();
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, N);
    check("done_busy", busy, 1);
    check("done_irb_rw", IRB_RW, 1);
    exp_done++;
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("post_done_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
    check("done_count", done_seen, exp_done);
  endtask

  initial begin
    // Load with a left-shift attempted while busy; the window must stay centred on (4,4).
    reset_load();
    write_out();

    issue(4'd5);
    model[27] = 36; model[28] = 36; model[35] = 36; model[36] = 36;
    write_out();

    reset_load();
    issue(4'd6);
    model[27] = 27; model[28] = 27; model[35] = 27; model[36] = 27;
    write_out();

    reset_load();
    issue(4'd9);
`ifdef LCD_CTRL_ROT_EN
    model[27] = 35; model[28] = 27; model[35] = 36; model[36] = 28;
`endif
    write_out();

    reset_load();
    repeat (5) issue(4'd1);
    issue(4'd7);
    model[3] = 7; model[4] = 7; model[11] = 7; model[12] = 7;
    repeat (4) issue(4'd4);
    issue(4'd5);
    model[6] = 15; model[7] = 15; model[14] = 15; model[15] = 15;
    issue(4'd12);
    repeat (8) issue(4'd2);
    issue(4'd6);
    model[54] = 54; model[55] = 54; model[62] = 54; model[63] = 54;
    write_out();

    // Abort a write-out at cycle 20 with reset, then reload and write again.
    start_write();
    repeat (20) @(negedge clk);
    check("abort_irb_a", IRB_A, 20);
    reset_load();
    write_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
